// File: rtl/period_meter_ddr.sv
// Averaged period meter for a square wave arriving as SAMPLES_PER_CLK-wide DDR sample words.
// Define PERIOD_METER_DDR_DUTY_EN to add falling-edge detection and the HIGH_OUT high-time average.
module period_meter_ddr #(
  parameter int SAMPLES_PER_CLK = 8,
  parameter int COUNTER_BITS    = 16,
  parameter int AVG_LOG2        = 4
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               CE,
  input  logic [SAMPLES_PER_CLK-1:0]         SAMPLE_IN,
  output logic [COUNTER_BITS+AVG_LOG2-1:0]   PERIOD_OUT,
  output logic                               PERIOD_VALID,
  output logic                               NO_SIGNAL
`ifdef PERIOD_METER_DDR_DUTY_EN
  ,
  output logic [COUNTER_BITS+AVG_LOG2-1:0]   HIGH_OUT
`endif
);

  localparam int PB = $clog2(SAMPLES_PER_CLK);
  localparam int OW = COUNTER_BITS + AVG_LOG2;
  localparam int WB = COUNTER_BITS - PB + 1;
  localparam int PW = COUNTER_BITS + 2;
  localparam logic [WB-1:0]       W_MAX    = {1'b1, {(WB-1){1'b0}}};
  localparam logic [WB-1:0]       W_ONE    = {{(WB-1){1'b0}}, 1'b1};
  localparam logic [AVG_LOG2-1:0] CNT_LAST = {AVG_LOG2{1'b1}};
  localparam logic [AVG_LOG2-1:0] CNT_ONE  = {{(AVG_LOG2-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  logic [SAMPLES_PER_CLK:0] stream_s;
  logic                     rise_s, rise_q;
  logic [PB-1:0]            rise_p_s, rise_p_q;
  logic                     prev_q;

  logic [1:0]               state_q, state_d;
  logic [WB-1:0]            w_q, w_d, wc_s;
  logic [PB-1:0]            last_p_q, last_p_d;
  logic [OW-1:0]            acc_q, acc_d, sum_s, out_q, out_d;
  logic [AVG_LOG2-1:0]      cnt_q, cnt_d;
  logic                     valid_q, valid_d, ns_q, ns_d;
  logic [PW-1:0]            per_s;
  logic                     per_ok_s, tmo_s, done_s;
  logic                     clr_s, accept_s, start_s;

  // First rising edge in the word; the previous word's last sample closes the stream at the bottom.
  always_comb begin
    stream_s = {SAMPLE_IN, prev_q};
    rise_s   = 1'b0;
    rise_p_s = '0;
    for (int i = SAMPLES_PER_CLK - 1; i >= 0; i--) begin
      rise_s   = rise_s | (stream_s[i+1] & ~stream_s[i]);
      rise_p_s = (stream_s[i+1] & ~stream_s[i]) ? PB'(i) : rise_p_s;
    end
  end

  // Stage 1: edge-detect register; prev_q tracks the line even while disabled.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_q   <= 1'b0;
      rise_q   <= 1'b0;
      rise_p_q <= '0;
    end else begin
      prev_q   <= SAMPLE_IN[SAMPLES_PER_CLK-1];
      rise_q   <= rise_s;
      rise_p_q <= rise_p_s;
    end
  end

  // wc_s counts the word being processed, so an edge one word after the last is wc_s=1.
  always_comb begin
    wc_s     = (w_q == W_MAX) ? W_MAX : (w_q + W_ONE);
    tmo_s    = (wc_s == W_MAX);
    per_s    = PW'({wc_s, {PB{1'b0}}}) + PW'(rise_p_q) - PW'(last_p_q);
    per_ok_s = (per_s[PW-1:COUNTER_BITS] == 2'b00);
    sum_s    = acc_q + OW'(per_s[COUNTER_BITS-1:0]);
    done_s   = (cnt_q == CNT_LAST);
  end

  // Stage 2: state machine, accumulation and output update.
  always_comb begin
    state_d  = state_q;
    w_d      = wc_s;
    last_p_d = last_p_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    ns_d     = ns_q;
    clr_s    = 1'b0;
    accept_s = 1'b0;
    start_s  = 1'b0;
    if (!CE) begin
      state_d = ST_IDLE;
      w_d     = '0;
      clr_s   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SYNC;
          w_d     = '0;
          clr_s   = 1'b1;
        end
        ST_SYNC: begin
          if (rise_q) begin
            start_s  = 1'b1;
            last_p_d = rise_p_q;
            w_d      = '0;
            state_d  = ST_MEAS;
          end else if (tmo_s) begin
            ns_d  = 1'b1;
            clr_s = 1'b1;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_MEAS: begin
          if (rise_q && per_ok_s) begin
            accept_s = 1'b1;
            last_p_d = rise_p_q;
            w_d      = '0;
            if (done_s) begin
              out_d   = sum_s;
              valid_d = 1'b1;
              ns_d    = 1'b0;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              acc_d = sum_s;
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (tmo_s) begin
            ns_d    = 1'b1;
            clr_s   = 1'b1;
            state_d = ST_SYNC;
          end else begin
            state_d = ST_MEAS;
          end
        end
        default: begin
          state_d = ST_IDLE;
          clr_s   = 1'b1;
        end
      endcase
    end
    acc_d = clr_s ? '0 : acc_d;
    cnt_d = clr_s ? '0 : cnt_d;
  end

  // Stage 2 registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      last_p_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ns_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      last_p_q <= last_p_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ns_q     <= ns_d;
    end
  end

  assign PERIOD_OUT   = out_q;
  assign PERIOD_VALID = valid_q;
  assign NO_SIGNAL    = ns_q;

`ifdef PERIOD_METER_DDR_DUTY_EN
  logic                    fall_s, fall_q, fall_before_s, fall_after_s;
  logic [PB-1:0]           fall_p_s, fall_p_q;
  logic [COUNTER_BITS-1:0] hf_s, close_s, hpend_q, hpend_d, new_pend_s;
  logic                    hhave_q, hhave_d;
  logic [OW-1:0]           hacc_q, hacc_d, hsum_s, high_q, high_d;

  // First falling edge in the word, same rule as the rising edge.
  always_comb begin
    fall_s   = 1'b0;
    fall_p_s = '0;
    for (int i = SAMPLES_PER_CLK - 1; i >= 0; i--) begin
      fall_s   = fall_s | (~stream_s[i+1] & stream_s[i]);
      fall_p_s = (~stream_s[i+1] & stream_s[i]) ? PB'(i) : fall_p_s;
    end
  end

  // A fall ahead of the rise closes the old period's high time; one after it opens the new period's.
  always_comb begin
    fall_before_s = fall_q & (~rise_q | (fall_p_q < rise_p_q));
    fall_after_s  = fall_q & rise_q & (fall_p_q > rise_p_q);
    hf_s          = COUNTER_BITS'(PW'({wc_s, {PB{1'b0}}}) + PW'(fall_p_q) - PW'(last_p_q));
    close_s       = hhave_q ? hpend_q : (fall_before_s ? hf_s : per_s[COUNTER_BITS-1:0]);
    hsum_s        = hacc_q + OW'(close_s);
    new_pend_s    = COUNTER_BITS'(fall_p_q) - COUNTER_BITS'(rise_p_q);
    hacc_d        = hacc_q;
    hhave_d       = hhave_q;
    hpend_d       = hpend_q;
    high_d        = high_q;
    if (clr_s) begin
      hacc_d  = '0;
      hhave_d = 1'b0;
    end else if (accept_s) begin
      hacc_d  = done_s ? '0 : hsum_s;
      high_d  = done_s ? hsum_s : high_q;
      hhave_d = fall_after_s;
      hpend_d = new_pend_s;
    end else if (start_s) begin
      hhave_d = fall_after_s;
      hpend_d = new_pend_s;
    end else if (CE && (state_q == ST_MEAS) && fall_before_s && !hhave_q) begin
      hhave_d = 1'b1;
      hpend_d = hf_s;
    end else begin
      hhave_d = hhave_q;
    end
  end

  // High-time pipeline and accumulator registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fall_q   <= 1'b0;
      fall_p_q <= '0;
      hhave_q  <= 1'b0;
      hpend_q  <= '0;
      hacc_q   <= '0;
      high_q   <= '0;
    end else begin
      fall_q   <= fall_s;
      fall_p_q <= fall_p_s;
      hhave_q  <= hhave_d;
      hpend_q  <= hpend_d;
      hacc_q   <= hacc_d;
      high_q   <= high_d;
    end
  end

  assign HIGH_OUT = high_q;
`endif

endmodule
